// File: rtl/uart_tx_fifo.sv
// Transmit byte queue in front of the UART transmitter: buffers bytes in a
// DEPTH-entry FIFO and launches them one at a time via tx_start/tx_busy.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    input  logic          flush,
    input  logic          tx_en,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_busy
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          overflow_reg;
    logic [7:0]    tx_data_reg;
    logic          tx_start_reg;
    logic [1:0]    guard_reg;
    state_t        state_reg;

    logic full_w;
    logic empty_w;
    logic wr_accept;
    logic launch;

    assign full_w  = (count_reg == CNT_FULL);
    assign empty_w = (count_reg == '0);

    // Flush wins over both the write and the launch in the same cycle.
    assign wr_accept = wr_en && !full_w && !flush;
    assign launch    = (state_reg == IDLE) && tx_en && !empty_w && !tx_busy && !flush;

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({wr_accept, launch})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase
        end
    end

    // Storage array kept free of reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            overflow_reg <= wr_en && full_w && !flush;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (wr_accept) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                end
                if (launch) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                end
            end
        end
    end

    // Drain FSM; a transmitter that never raises busy is timed out after
    // three WAIT_BUSY cycles and the byte counts as sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            guard_reg    <= 2'd0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        tx_data_reg  <= mem[rd_ptr_reg];
                        tx_start_reg <= 1'b1;
                        state_reg    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tx_start_reg <= 1'b0;
                    guard_reg    <= 2'd0;
                    state_reg    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_reg <= WAIT_DONE;
                    end else if (guard_reg == 2'd2) begin
                        state_reg <= IDLE;
                    end else begin
                        guard_reg <= guard_reg + 2'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    tx_start_reg <= 1'b0;
                end
            endcase
        end
    end

    assign full     = full_w;
    assign empty    = empty_w;
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign tx_data  = tx_data_reg;
    assign tx_start = tx_start_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: a queue-based reference FIFO plus a
// behavioural UART busy responder, with a negedge monitor doing the checks.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          flush;
    logic          tx_en;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .flush    (flush),
        .tx_en    (tx_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART responder: busy rises the cycle after tx_start is sampled and
    // stays up for 1..5 cycles; uart_dead models a transmitter that never answers.
    logic uart_dead = 1'b0;
    int   busy_rem;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy  <= 1'b0;
            busy_rem <= 0;
        end else if (tx_start && !uart_dead) begin
            tx_busy  <= 1'b1;
            busy_rem <= int'($urandom_range(0, 4));
        end else if (tx_busy) begin
            if (busy_rem == 0) tx_busy <= 1'b0;
            else busy_rem <= busy_rem - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    logic [7:0] model_q[$];
    logic       exp_ovf;
    logic       prev_start, prev_en, prev_flush, prev_busy;
    int         last_fall;
    int         n_starts = 0;
    int         start_log[$];

    initial begin
        logic [7:0] exp_byte;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_q.delete();
                exp_ovf    = 1'b0;
                prev_start = 1'b0;
                prev_en    = 1'b0;
                prev_flush = 1'b0;
                prev_busy  = 1'b0;
                last_fall  = -100;
                check("rst_count", 32'(count), 0);
                check("rst_empty", 32'(empty), 1);
                check("rst_full", 32'(full), 0);
                check("rst_overflow", 32'(overflow), 0);
                check("rst_tx_start", 32'(tx_start), 0);
                check("rst_tx_data", 32'(tx_data), 0);
            end else begin
                if (tx_start) begin
                    n_starts++;
                    start_log.push_back(cyc);
                    check("start_single_cycle", 32'(prev_start), 0);
                    check("start_while_busy", 32'(tx_busy), 0);
                    check("start_gated", 32'(prev_en && !prev_flush), 1);
                    check("start_gap_after_busy", 32'(cyc - last_fall >= 2), 1);
                    check("start_nonempty", 32'(model_q.size() != 0), 1);
                    if (model_q.size() != 0) begin
                        exp_byte = model_q.pop_front();
                        check("tx_data", 32'(tx_data), 32'(exp_byte));
                    end
                end
                check("count", 32'(count), 32'(model_q.size()));
                check("full", 32'(full), 32'(model_q.size() == DEPTH));
                check("empty", 32'(empty), 32'(model_q.size() == 0));
                check("overflow", 32'(overflow), 32'(exp_ovf));
                if (prev_busy && !tx_busy) last_fall = cyc;
                if (flush) begin
                    model_q.delete();
                    exp_ovf = 1'b0;
                end else if (wr_en) begin
                    if (model_q.size() == DEPTH) begin
                        exp_ovf = 1'b1;
                    end else begin
                        model_q.push_back(wr_data);
                        exp_ovf = 1'b0;
                    end
                end else begin
                    exp_ovf = 1'b0;
                end
                prev_start = tx_start;
                prev_en    = tx_en;
                prev_flush = flush;
                prev_busy  = tx_busy;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_data = b;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain();
        int quiet = 0;
        for (int i = 0; i < 3000 && quiet < 6; i++) begin
            tick();
            if (empty && !tx_busy && !tx_start) quiet++;
            else quiet = 0;
        end
        check("drain_done", 32'(quiet >= 6), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int seen;
        rst = 1'b1; wr_data = 8'h00; wr_en = 1'b0; flush = 1'b0; tx_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single byte latency
        tx_en = 1'b1;
        wr_data = 8'hA5; wr_en = 1'b1;
        n0 = cyc;
        tick();
        wr_en = 1'b0;
        tick();
        check("single_start_n2", 32'(tx_start), 1);
        check("single_cycle", 32'(cyc - n0), 2);
        check("single_data", 32'(tx_data), 32'hA5);
        check("single_empty", 32'(empty), 1);
        wait_drain();

        // Burst fill, overflow, ordered drain
        tx_en = 1'b0;
        for (int i = 1; i <= 16; i++) push(8'(i));
        check("burst_full", 32'(full), 1);
        push(8'hFF);
        tick();
        check("ovf_count", 32'(count), 16);
        n0 = n_starts;
        tx_en = 1'b1;
        wait_drain();
        check("burst_starts", 32'(n_starts - n0), 16);

        // Wrap-around: push 3, drain, 40 bytes total
        n0 = n_starts;
        for (int i = 0; i < 40; i += 3) begin
            for (int j = i; j < i + 3 && j < 40; j++) push(8'($urandom));
            wait_drain();
        end
        check("wrap_starts", 32'(n_starts - n0), 40);
        check("wrap_count", 32'(count), 0);

        // Random traffic with occasional flushes
        for (int i = 0; i < 1500; i++) begin
            wr_data = 8'($urandom);
            wr_en   = ($urandom % 3) != 0;
            tx_en   = ($urandom % 4) != 0;
            flush   = ($urandom % 60) == 0;
            tick();
        end
        wr_en = 1'b0; flush = 1'b0; tx_en = 1'b1;
        wait_drain();

        // Flush while a frame is in flight
        tx_en = 1'b0;
        for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
        tx_en = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (tx_busy) seen = 1;
        end
        check("flush_busy_seen", 32'(seen), 1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n0 = n_starts;
        for (int i = 0; i < 30; i++) tick();
        check("flush_no_start", 32'(n_starts - n0), 0);
        check("flush_count", 32'(count), 0);
        check("flush_empty", 32'(empty), 1);

        // Guard timeout with a silent transmitter
        uart_dead = 1'b1;
        tx_en = 1'b0;
        push(8'h11);
        push(8'h22);
        n0 = n_starts;
        tx_en = 1'b1;
        for (int i = 0; i < 40 && (n_starts - n0) < 2; i++) tick();
        check("timeout_starts", 32'(n_starts - n0), 2);
        if (n_starts - n0 >= 2)
            check("timeout_spacing", 32'(start_log[$] - start_log[$-1]), 5);
        wait_drain();
        uart_dead = 1'b0;

        // Reset asserted during LAUNCH
        tx_en = 1'b0;
        for (int i = 0; i < 3; i++) push(8'h70 + 8'(i));
        tx_en = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (tx_start) seen = 1;
        end
        check("rst_launch_seen", 32'(seen), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_start", 32'(tx_start), 0);
        check("rst_async_count", 32'(count), 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("post_rst_data", 32'(tx_data), 0);
        check("post_rst_count", 32'(count), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer that sits directly upstream of the UART core's transmitter. Software or host logic pushes bytes at any rate. The block queues them in a DEPTH-entry FIFO and drains them one at a time through the core's `tx_data` / `tx_start` / `tx_busy` handshake, launching the next byte only after the previous frame has fully completed.

## Interface
- `DEPTH`, default 16: FIFO entries; must be a power of two, at least 2.
- `AW`, default `$clog2(DEPTH)`: pointer width; derived, not overridden.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_data`  in  8  byte to enqueue.
- `wr_en`  in  1  enqueue strobe; one byte per cycle while high.
- `flush`  in  1  synchronous clear of FIFO contents.
- `tx_en`  in  1  drain enable; while low no new byte is launched.
- `full`  out  1  high when count == DEPTH.
- `empty`  out  1  high when count == 0.
- `count`  out  AW+1  bytes currently queued; excludes the byte in flight.
- `overflow`  out  1  one-cycle pulse when a write is dropped.
- `tx_data`  out  8  byte presented to the UART core; registered.
- `tx_start`  out  1  one-cycle launch pulse to the UART core; registered.
- `tx_busy`  in  1  transmitter-busy indication from the UART core.

## Operation
- Storage: 8-bit × DEPTH register array; `wr_ptr` and `rd_ptr` are AW bits wide and wrap modulo DEPTH; `count` is a separate AW+1-bit register.
- Write: if `wr_en` && !`full` (as registered at the start of the cycle), store `mem[wr_ptr]` and increment `wr_ptr`.
- Write when full: if `wr_en` && `full`, drop the byte and pulse `overflow` for 1 cycle. This holds even if a pop happens in the same cycle.
- Simultaneous accepted write and pop: `count` is unchanged and both pointers advance.
- Drain FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE: if `tx_en` && !`empty` && !`tx_busy`, then on the same edge:
    - set `tx_data` <= `mem[rd_ptr]`, `tx_start` <= 1;
    - increment `rd_ptr`, decrement `count`;
    - go to LAUNCH.
  - LAUNCH (1 cycle; `tx_start` high): clear `tx_start`, go to WAIT_BUSY.
  - WAIT_BUSY: if `tx_busy`=1, go to WAIT_DONE. A 2-bit guard counter runs here; if `tx_busy` is still low after 3 cycles, return to IDLE and treat the byte as consumed.
  - WAIT_DONE: when `tx_busy`=0, go to IDLE.
- `tx_data` holds its value from launch until the next launch; it is never cleared except by reset.
- `flush`:
  - zeroes `wr_ptr`, `rd_ptr` and `count`;
  - any `wr_en` in the same cycle is ignored, with no `overflow` pulse;
  - the FSM state is unaffected, so a byte already launched completes normally;
  - if asserted in IDLE, it also blocks a launch in that cycle.
- `tx_en` low does not abort an in-flight byte; it only gates the IDLE→LAUNCH transition.

## Timing
- Reset values: `full`=0, `empty`=1, `count`=0, `overflow`=0, `tx_start`=0, `tx_data`=8'h00, FSM=IDLE, pointers=0.
- Reset mid-operation: all state clears immediately, `tx_start` drops asynchronously, and queued bytes are lost.
- `full`, `empty` and `count` reflect registered state and update the cycle after the write or pop edge.
- Latency with FIFO empty, FSM in IDLE, `tx_en`=1, `tx_busy`=0:
  - `wr_en` in cycle N → `count`=1 in N+1 → `tx_start` high in N+2.
- The UART core raises `tx_busy` the cycle after it samples `tx_start`, so WAIT_BUSY normally lasts 1 cycle.
- Back-to-back bytes: the next `tx_start` comes no earlier than 2 cycles after `tx_busy` falls (WAIT_DONE→IDLE, then IDLE→LAUNCH).
- `tx_start` is never high for more than 1 consecutive cycle. It is never asserted while `tx_busy`=1.
- At most one byte is in flight; `count` + in-flight ≤ DEPTH + 1.

## Test plan
- Single byte: reset, write 8'hA5 in cycle N with `tx_busy` model responding → `tx_start`=1 exactly in N+2 with `tx_data`=8'hA5; `empty`=1 from N+2.
- Burst/order: write 8'h01..8'h10 back-to-back (DEPTH=16) → `full`=1 after the 16th write, before any pop. Drain completes with the 16 `tx_start` pulses carrying 01..10 in order, each launched only after `tx_busy` falls.
- Overflow: with FIFO full and `tx_en`=0, write 8'hFF → `overflow` pulses 1 cycle, `count` stays 16. Enable `tx_en` → 8'hFF never appears on `tx_data`.
- Wrap-around: repeatedly push 3 and drain 3 for 40 bytes (pointers wrap twice) → output sequence equals input sequence, `count` returns to 0.
- Flush mid-transfer: queue 5 bytes, assert `flush` while in WAIT_DONE → the in-flight byte finishes, no further `tx_start`, `count`=0, `empty`=1.
- Guard timeout/reset: hold `tx_busy`=0 permanently after a launch → FSM returns to IDLE 3 cycles after LAUNCH and launches the next byte. Assert `rst` during LAUNCH → `tx_start` drops immediately, `count`=0.
